operand_entry: RTL and testbench

Sequential operand-entry front end for the 4-bit adder/seven-segment board design. It takes one raw active-low pushbutton and the slide switches, then debounces the button and turns each press into a single event. A three-phase FSM uses those events to latch operand A, then operand B with carry-in, and then present both to the adder datapath. It replaces direct switch wiring, so A, B and Cin are entered one after another through the same four switches.

---
 rtl/calc_pkg.sv | 13 +
 rtl/key_debounce.sv | 57 +++++
 rtl/operand_entry.sv | 106 ++++++++++
 tb/tb_operand_entry.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared types and widths for the adder/seven-segment calculator.
// The phase encoding is also what the HEX status display shows.
package calc_pkg;

  localparam int OPERAND_W = 4;

  typedef enum logic [1:0] {
    LOAD_A = 2'b00,
    LOAD_B = 2'b01,
    SHOW   = 2'b10
  } phase_t;

endpackage

// File: rtl/key_debounce.sv
// Synchronises and debounces one active-low pushbutton. Each accepted
// press appears on press for exactly one clock.
module key_debounce
  import calc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic press
);

  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic             db_q, db_d;
  logic             db_dly_q, db_dly_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next-state logic: a level change is accepted only after it has held for DEBOUNCE_CYCLES edges
  always_comb begin
    s1_d     = key_n;
    s2_d     = s1_q;
    db_dly_d = db_q;
    db_d     = db_q;
    cnt_d    = cnt_q;
    if (s2_q == db_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      db_d  = s2_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State registers; the synchroniser and debounced level idle high (released)
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q     <= 1'b1;
      s2_q     <= 1'b1;
      db_q     <= 1'b1;
      db_dly_q <= 1'b1;
      cnt_q    <= '0;
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      db_q     <= db_d;
      db_dly_q <= db_dly_d;
      cnt_q    <= cnt_d;
    end
  end

  assign press = db_dly_q & ~db_q;

endmodule

// File: rtl/operand_entry.sv
// Three-phase operand entry: button presses latch A, then B with carry-in,
// then present both to the adder until the next press clears them.
module operand_entry
  import calc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 key_n,
  input  logic [OPERAND_W-1:0] sw_val,
  input  logic                 sw_cin,
  output logic [OPERAND_W-1:0] a_out,
  output logic [OPERAND_W-1:0] b_out,
  output logic                 cin_out,
  output logic                 operands_valid,
  output logic [1:0]           phase
);

  logic                 press;
  // Plain vector so the unused 2'b11 code stays representable and recoverable
  logic [1:0]           phase_q, phase_d;
  logic [OPERAND_W-1:0] a_q, a_d;
  logic [OPERAND_W-1:0] b_q, b_d;
  logic                 cin_q, cin_d;
  logic                 valid_q, valid_d;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_key_debounce (
    .clk  (clk),
    .reset(reset),
    .key_n(key_n),
    .press(press)
  );

  // Phase sequencing; switches are looked at only in the press cycle
  always_comb begin
    phase_d = phase_q;
    a_d     = a_q;
    b_d     = b_q;
    cin_d   = cin_q;
    case (phase_q)
      LOAD_A: begin
        if (press) begin
          a_d     = sw_val;
          phase_d = LOAD_B;
        end else begin
          phase_d = LOAD_A;
        end
      end
      LOAD_B: begin
        if (press) begin
          b_d     = sw_val;
          cin_d   = sw_cin;
          phase_d = SHOW;
        end else begin
          phase_d = LOAD_B;
        end
      end
      SHOW: begin
        if (press) begin
          a_d     = '0;
          b_d     = '0;
          cin_d   = 1'b0;
          phase_d = LOAD_A;
        end else begin
          phase_d = SHOW;
        end
      end
      default: begin
        a_d     = '0;
        b_d     = '0;
        cin_d   = 1'b0;
        phase_d = LOAD_A;
      end
    endcase
    valid_d = (phase_d == SHOW);
  end

  // Capture and status registers
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q <= LOAD_A;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cin_q   <= cin_d;
      valid_q <= valid_d;
    end
  end

  assign a_out          = a_q;
  assign b_out          = b_q;
  assign cin_out        = cin_q;
  assign operands_valid = valid_q;
  assign phase          = phase_q;

endmodule

// File: tb/tb_operand_entry.sv
// Scoreboard bench for operand_entry with DEBOUNCE_CYCLES=4: every output
// change must match the next queued expectation, including its edge number.
module tb_operand_entry;

  logic       clk = 1'b0;
  logic       reset;
  logic       key_n;
  logic [3:0] sw_val;
  logic       sw_cin;
  logic [3:0] a_out, b_out;
  logic       cin_out, operands_valid;
  logic [1:0] phase;

  typedef struct {
    logic [11:0] val;
    int          edge_n;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  logic        mon_en = 1'b0;
  logic [11:0] prev_obs;

  operand_entry #(.DEBOUNCE_CYCLES(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .key_n         (key_n),
    .sw_val        (sw_val),
    .sw_cin        (sw_cin),
    .a_out         (a_out),
    .b_out         (b_out),
    .cin_out       (cin_out),
    .operands_valid(operands_valid),
    .phase         (phase)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [11:0] pk(input logic [1:0] ph, input logic [3:0] a,
                                     input logic [3:0] b, input logic cin, input logic v);
    return {ph, a, b, cin, v};
  endfunction

  // Monitor: any change of the observable outputs must be the next scoreboard entry
  always @(negedge clk) begin
    logic [11:0] obs;
    exp_t        e;
    obs = {phase, a_out, b_out, cin_out, operands_valid};
    if (mon_en && (obs !== prev_obs)) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_change at edge %0d: got %h, expected no change from %h",
                 cyc, obs, prev_obs);
      end else begin
        e = sb.pop_front();
        vectors++;
        if (obs !== e.val) begin
          miscompares++;
          $display("FAIL %s value: got %h, expected %h", e.name, obs, e.val);
        end
        vectors++;
        if (cyc != e.edge_n) begin
          miscompares++;
          $display("FAIL %s edge: got edge %0d, expected edge %0d", e.name, cyc, e.edge_n);
        end
      end
    end
    prev_obs = obs;
  end

  task automatic expect_at(input logic [11:0] v, input int edge_n, input string nm);
    exp_t e;
    e.val = v;
    e.edge_n = edge_n;
    e.name = nm;
    sb.push_back(e);
  endtask

  // Clean press: key low for low_n cycles, then a long release
  task automatic do_press(input logic [11:0] v, input int low_n, input string nm);
    @(posedge clk); #1;
    key_n = 1'b0;
    expect_at(v, cyc + 7, nm);
    repeat (low_n) @(posedge clk);
    #1 key_n = 1'b1;
    repeat (12) @(posedge clk);
  endtask

  initial begin
    int   e0;
    int   c;
    logic [3:0] t;
    logic [3:0] b_exp;

    reset = 1'b1; key_n = 1'b0; sw_val = 4'h3; sw_cin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({phase, a_out, b_out, cin_out, operands_valid} !== 12'h000) begin
      miscompares++;
      $display("FAIL reset_state: got %h, expected %h",
               {phase, a_out, b_out, cin_out, operands_valid}, 12'h000);
    end
    mon_en = 1'b1;
    // Button already held at reset release: one press, capture 7 edges later
    expect_at(pk(2'b01, 4'h3, 4'h0, 1'b0, 1'b0), cyc + 7, "held_at_reset");
    reset = 1'b0;
    repeat (10) @(posedge clk);
    #1 key_n = 1'b1;
    repeat (12) @(posedge clk);

    // Switch isolation in LOAD_B: sw_val changes every cycle
    b_exp = 4'h0;
    for (int i = 0; i < 34; i++) begin
      @(posedge clk); #1;
      c = cyc;
      t = c[3:0];
      sw_val = t ^ 4'h5;
      if (i == 10) begin
        key_n = 1'b0;
        c = cyc + 6;
        t = c[3:0];
        b_exp = t ^ 4'h5;
        expect_at(pk(2'b10, 4'h3, b_exp, 1'b0, 1'b1), cyc + 7, "sw_isolation");
      end else if (i == 22) begin
        key_n = 1'b1;
      end else begin
        key_n = key_n;
      end
    end
    repeat (4) @(posedge clk);
    do_press(pk(2'b00, 4'h0, 4'h0, 1'b0, 1'b0), 10, "clear_1");

    // Full sequence
    sw_val = 4'h9; sw_cin = 1'b0;
    do_press(pk(2'b01, 4'h9, 4'h0, 1'b0, 1'b0), 10, "seq_a");
    sw_val = 4'hB; sw_cin = 1'b1;
    do_press(pk(2'b10, 4'h9, 4'hB, 1'b1, 1'b1), 10, "seq_b");
    sw_val = 4'h4; sw_cin = 1'b0;
    do_press(pk(2'b00, 4'h0, 4'h0, 1'b0, 1'b0), 10, "seq_clear");

    // Bounce: toggle every 2 cycles, then settle low
    sw_val = 4'h6;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      key_n = i[0];
      @(posedge clk);
    end
    @(posedge clk); #1;
    key_n = 1'b0;
    expect_at(pk(2'b01, 4'h6, 4'h0, 1'b0, 1'b0), cyc + 7, "bounce");
    repeat (10) @(posedge clk);
    #1 key_n = 1'b1;
    repeat (12) @(posedge clk);

    // 3-cycle glitch: must not capture
    sw_val = 4'hE;
    @(posedge clk); #1;
    key_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 key_n = 1'b1;
    repeat (15) @(posedge clk);

    // Long hold: a single event
    sw_val = 4'h2; sw_cin = 1'b0;
    do_press(pk(2'b10, 4'h6, 4'h2, 1'b0, 1'b1), 100, "hold");
    do_press(pk(2'b00, 4'h0, 4'h0, 1'b0, 1'b0), 10, "clear_2");

    // Reset while the LOAD_B press is mid-debounce (counter at 2)
    sw_val = 4'h5;
    do_press(pk(2'b01, 4'h5, 4'h0, 1'b0, 1'b0), 10, "pre_reset_a");
    sw_val = 4'hA;
    @(posedge clk); #1;
    key_n = 1'b0;
    e0 = cyc;
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    expect_at(pk(2'b00, 4'h0, 4'h0, 1'b0, 1'b0), e0 + 5, "reset_mid");
    @(posedge clk); #1;
    reset = 1'b0;
    key_n = 1'b1;
    repeat (20) @(posedge clk);
    sw_val = 4'h7;
    do_press(pk(2'b01, 4'h7, 4'h0, 1'b0, 1'b0), 10, "after_reset_a");

    repeat (10) @(posedge clk);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL missing_events: got %0d outstanding, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
